// File: rtl/muldiv_if.sv
// muldiv_if: issue/result handshake between the operand-select stage and the iterative multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic             kill;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    modport master (output start, kill, funct3, op_a, op_b, input busy, done, result);
    modport slave (input start, kill, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative RV32M multiply/divide unit with start/busy/done handshake.
module muldiv_unit #(parameter int WIDTH = 32) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2;
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d, negr_q, negr_d, done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               accept, signed_a, signed_b, sa, sb, dz, ovf, special;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fin_val;
    logic [WIDTH:0]     msum, rs, diff;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
    assign accept   = state_q == IDLE && bus.start && !bus.kill;
    assign signed_b = bus.funct3 == 3'b001 || (bus.funct3[2] && !bus.funct3[0]);
    assign signed_a = signed_b || bus.funct3 == 3'b010;
    assign sa       = signed_a && bus.op_a[WIDTH-1];
    assign sb       = signed_b && bus.op_b[WIDTH-1];
    assign mag_a    = sa ? -bus.op_a : bus.op_a;
    assign mag_b    = sb ? -bus.op_b : bus.op_b;
    assign dz       = bus.funct3[2] && bus.op_b == '0;
    assign ovf      = bus.funct3[2] && !bus.funct3[0] && bus.op_a == {1'b1, {(WIDTH-1){1'b0}}} && bus.op_b == {WIDTH{1'b1}};
    assign special  = dz || ovf;
    // Product accumulates in the upper half while the multiplier drains out of the lower half.
    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_nx   = acc_q[0] ? {msum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    // Shifted partial remainder can need one extra bit; the borrow of diff is the compare.
    assign rs       = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rs - {1'b0, opnd_q};
    assign div_nx   = diff[WIDTH] ? {rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign prod     = neg_q ? -acc_q : acc_q;
    assign quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem      = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign fin_val  = f3_q[2] ? (f3_q[1] ? rem : quo) : (f3_q == 3'b000 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (accept) begin
            state_d = special ? FIN : CALC;
            cnt_d   = '0;
            f3_d    = bus.funct3;
            opnd_d  = bus.funct3[2] ? mag_b : mag_a;
            // Special divides preload {rem,quo} so FIN's normal selection yields the fixed answer.
            acc_d   = dz ? {bus.op_a, {WIDTH{1'b1}}} : ovf ? {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}} :
                      {{WIDTH{1'b0}}, bus.funct3[2] ? mag_a : mag_b};
            neg_d   = (sa ^ sb) && !special;
            negr_d  = sa && !special;
        end else if (state_q != IDLE && bus.kill) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            acc_d   = f3_q[2] ? div_nx : mul_nx;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(WIDTH - 1) ? FIN : CALC;
        end else if (state_q == FIN) begin
            done_d   = !done_q;
            result_d = done_q ? result_q : fin_val;
            state_d  = done_q ? IDLE : FIN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end
    assign bus.busy   = state_q != IDLE;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic RV32M reference.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    muldiv_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_lat = 0;
    logic [31:0] last_res = '0;
    logic [31:0] exp_q[$];
    int cyc_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, req, $time);
        end
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'b0, a};
        longint ub = {32'b0, b};
        logic [63:0] p;
        logic ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ov ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction
    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    endfunction
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                check("result", bus.result, exp_q.pop_front());
                check("done_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
                check("busy_at_done", {31'b0, bus.busy}, 32'd1);
            end
        end
    end
    // Waits for idle while hammering start with junk that the busy unit must ignore.
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            bus.start = 1'($urandom);
            bus.funct3 = 3'($urandom);
            bus.op_a = $urandom;
            bus.op_b = $urandom;
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("idle_timeout", 32'(n), 32'd0);
        else if (last_lat > 0) check("busy_cycles", 32'(n), 32'(last_lat + 1));
        last_lat = 0;
    endtask
    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        wait_idle();
        bus.start = 1'b1;
        bus.kill = 1'b0;
        bus.funct3 = f;
        bus.op_a = a;
        bus.op_b = b;
        if (expect_done) begin
            exp_q.push_back(model(f, a, b));
            cyc_q.push_back(cyc + 1 + latency(f, a, b));
            last_res = model(f, a, b);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        last_lat = expect_done ? latency(f, a, b) : 0;
    endtask
    initial begin
        logic [31:0] a, b;
        int n;
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.funct3 = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        #12;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
        drive(3'd0, 32'd7, 32'd6, 1);
        drive(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        drive(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        drive(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
        drive(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
        drive(3'd5, 32'd100, 32'd7, 1);
        drive(3'd4, 32'h1234_5678, 32'd0, 1);
        drive(3'd6, 32'h1234_5678, 32'd0, 1);
        drive(3'd5, 32'h8765_4321, 32'd0, 1);
        drive(3'd7, 32'h8765_4321, 32'd0, 1);
        drive(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        drive(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        drive(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        drive(3'd5, $urandom, $urandom, 0);
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_busy", {31'b0, bus.busy}, 32'd0);
        check("kill_result_held", bus.result, last_res);
        drive(3'd0, 32'd3, 32'd5, 1);
        wait_idle();
        bus.start = 1'b1;
        bus.kill = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill = 1'b0;
        check("idle_kill_beats_start", {31'b0, bus.busy}, 32'd0);
        drive(3'd1, $urandom, $urandom, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("async_rst_done", {31'b0, bus.done}, 32'd0);
        check("async_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF, 1);
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> $urandom_range(1, 31);
                3: a = a >> $urandom_range(1, 31);
                default: ;
            endcase
            drive(3'($urandom), a, b, 1);
        end
        wait_idle();
        bus.start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the multi-cycle variant of the core.
- Sits downstream of the ALU operand-select muxes and consumes the selected op_a/op_b operand pair when an M-extension instruction issues.
- Returns a 32-bit result to the writeback path through a start/busy/done handshake.
- Radix-2: one product bit or one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported and verified.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  issue request; sampled only in IDLE.
kill  in  1  synchronous abort of the current operation (pipeline flush).
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  in  WIDTH  rs1 operand (multiplicand/dividend).
op_b  in  WIDTH  rs2 operand (multiplier/divisor).
busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
done  out  1  one-cycle pulse; result is valid in that cycle.
result  out  WIDTH  final value; held until the next accepted start or reset.

Behaviour:
- Reset is asynchronous and active-low: one clock, clk; reset rst_n.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately and produces no done.
- States:
  - IDLE: start=1 and kill=0 captures funct3 and the operands.
  - Signed ops (MULH: both operands signed; MULHSU: op_a only; DIV/REM: both) store magnitudes plus the required result sign.
  - Special divide cases go to FIN directly. All other ops go to CALC with cnt=0.
  - CALC: exactly 32 cycles, cnt 0..31, then FIN.
  - Multiply: 64-bit shift-add. If the multiplier LSB is set, add the multiplicand into the upper half, then shift right by 1.
  - Divide: restoring division. Shift {rem,quo} left by 1; if rem >= divisor, subtract and set the quotient LSB.
  - FIN: apply sign correction (two's-complement negate of the 64-bit product, quotient, or remainder).
  - FIN: register result, pulse done=1, return to IDLE next cycle.
- Result selection:
  - MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder sign follows the dividend; quotient sign = sign(a) XOR sign(b).
- Latency: start accepted at edge E0.
  - Normal ops: done high in the cycle after edge E33 (34 cycles).
  - Special cases: done high in the cycle after E1.
- Divide by zero (op_b=0, any divide op):
  - DIV/DIVU: result=0xFFFFFFFF.
  - REM/REMU: result=op_a.
- Signed overflow (DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF): DIV result=0x80000000, REM result=0.
- Handshake:
  - start while busy is ignored; operands are not re-sampled.
  - Operands may change freely after the accept edge.
  - The writeback stage must take result during done.
- kill:
  - In CALC or FIN: next state IDLE, busy=0, no done, result keeps its previous value.
  - In IDLE: kill has priority over a simultaneous start, which is dropped.
- Back-to-back: start asserted in the done cycle is ignored (state is FIN). Accept occurs the next cycle.

Test Plan:
1. MULH 0x80000000 x 0x80000000; MUL 7 x 6 -> result 0x40000000 then 0x0000002A, each with done 34 cycles after start, busy high throughout.
2. MULHSU op_a=0xFFFFFFFF op_b=0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFF then 0xFFFFFFFE.
3. DIV -7/2 then REM -7/2 (op_a=0xFFFFFFF9, op_b=2); DIVU 100/7 -> 0xFFFFFFFD, 0xFFFFFFFF, 0x0000000E.
4. DIV/REM 0x12345678 by 0; DIV/REM 0x80000000 by 0xFFFFFFFF -> 0xFFFFFFFF/0x12345678 and 0x80000000/0x00000000, each with done in the cycle after E1 (2-cycle latency).
5. Start DIVU, assert kill at cnt=10, then start MUL 3x5 the next cycle -> no done for the killed op, busy low after kill, MUL returns 0x0000000F normally.
6. Drop rst_n mid-CALC, then assert start while busy on a fresh op -> all outputs 0 asynchronously; the second start is ignored and only one done pulse is seen.
